axi_stream_remove_header: RTL and testbench

Strips a variable-length header (1..DATA_BYTE_WD bytes) from the front of each AXI-Stream packet. The stripped bytes go out on a separate header channel. The remaining payload is realigned so it starts on the MSB byte lane. It is the receive-side counterpart of `axi_stream_insert_header` and sits between the packet source and downstream payload consumers.

---
 rtl/axi_stream_remove_header.sv | 170 +++++++++++++++++
 tb/tb_axi_stream_remove_header.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_stream_remove_header.sv
// Strips a 1..DATA_BYTE_WD byte header from each AXI-Stream packet, sends it on a
// separate header channel and realigns the remaining payload to the MSB byte lane.
module axi_stream_remove_header #(
  parameter int unsigned DATA_WD      = 32,
  parameter int unsigned DATA_BYTE_WD = DATA_WD / 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          valid_len,
  output logic                          ready_len,
  input  logic [$clog2(DATA_BYTE_WD):0] len_in,
  input  logic                          valid_in,
  output logic                          ready_in,
  input  logic [DATA_WD-1:0]            data_in,
  input  logic [DATA_BYTE_WD-1:0]       keep_in,
  input  logic                          last_in,
  output logic                          valid_out,
  input  logic                          ready_out,
  output logic [DATA_WD-1:0]            data_out,
  output logic [DATA_BYTE_WD-1:0]       keep_out,
  output logic                          last_out,
  output logic                          valid_hdr,
  input  logic                          ready_hdr,
  output logic [DATA_WD-1:0]            header_out,
  output logic [DATA_BYTE_WD-1:0]       keep_hdr
);

  localparam int unsigned LEN_WD = $clog2(DATA_BYTE_WD) + 1;
  localparam int unsigned SEL_WD = $clog2(DATA_BYTE_WD);

  typedef enum logic [1:0] {IDLE, FIRST, STREAM, FLUSH} state_t;

  state_t              state;
  logic [LEN_WD-1:0]   len_q;
  logic [LEN_WD-1:0]   flush_len_q;
  logic [DATA_WD-1:0]  res_q;

  logic [LEN_WD-1:0]   n;
  logic [SEL_WD-1:0]   s;
  logic [SEL_WD-1:0]   r_sel;
  logic [LEN_WD-1:0]   s_len, r_len, hdr_len, pay_len, tail_len, flush_len;
  logic [DATA_WD-1:0]  first_pay, merged, tail_data;
  logic                out_free, hdr_free, in_fire, len_fire;

  // Top k byte lanes enabled.
  function automatic logic [DATA_BYTE_WD-1:0] keep_of(input logic [LEN_WD-1:0] k);
    logic [DATA_BYTE_WD-1:0] m;
    m = '0;
    for (int i = 0; i < int'(DATA_BYTE_WD); i++)
      if (LEN_WD'(i) < k) m[DATA_BYTE_WD-1-i] = 1'b1;
    return m;
  endfunction

  function automatic logic [DATA_WD-1:0] bytes_of(input logic [DATA_BYTE_WD-1:0] k);
    logic [DATA_WD-1:0] m;
    for (int i = 0; i < int'(DATA_BYTE_WD); i++) m[i*8 +: 8] = {8{k[i]}};
    return m;
  endfunction

  always_comb begin
    n = '0;
    for (int i = 0; i < int'(DATA_BYTE_WD); i++) n = n + LEN_WD'(keep_in[i]);
  end

  // s = header bytes landing in the first beat modulo W; r = residue carried per beat
  assign s         = len_q[SEL_WD-1:0];
  assign s_len     = LEN_WD'(s);
  assign r_len     = LEN_WD'(DATA_BYTE_WD) - s_len;
  assign r_sel     = SEL_WD'(r_len);
  assign hdr_len   = (len_q < n) ? len_q : n;
  assign pay_len   = n - len_q;
  assign tail_len  = r_len + n;
  assign flush_len = n - s_len;
  assign first_pay = data_in << {len_q, 3'b000};
  assign tail_data = res_q << {s, 3'b000};
  assign merged    = tail_data | (data_in >> {r_sel, 3'b000});

  assign out_free  = !valid_out || ready_out;
  assign hdr_free  = !valid_hdr || ready_hdr;
  assign ready_len = rst_n && (state == IDLE);
  assign ready_in  = rst_n && (((state == FIRST) && out_free && hdr_free) ||
                               ((state == STREAM) && out_free));
  assign in_fire   = valid_in && ready_in;
  assign len_fire  = valid_len && ready_len;

  // Control FSM with registered payload and header output slots.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      len_q       <= '0;
      flush_len_q <= '0;
      res_q       <= '0;
      valid_out   <= 1'b0;
      data_out    <= '0;
      keep_out    <= '0;
      last_out    <= 1'b0;
      valid_hdr   <= 1'b0;
      header_out  <= '0;
      keep_hdr    <= '0;
    end else begin
      if (valid_out && ready_out) valid_out <= 1'b0;
      if (valid_hdr && ready_hdr) valid_hdr <= 1'b0;
      case (state)
        IDLE: begin
          if (len_fire) begin
            len_q <= len_in;
            state <= FIRST;
          end
        end
        FIRST: begin
          if (in_fire) begin
            valid_hdr  <= 1'b1;
            header_out <= data_in & bytes_of(keep_of(hdr_len));
            keep_hdr   <= keep_of(hdr_len);
            if (last_in) begin
              if (n > len_q) begin
                valid_out <= 1'b1;
                data_out  <= first_pay & bytes_of(keep_of(pay_len));
                keep_out  <= keep_of(pay_len);
                last_out  <= 1'b1;
              end
              state <= IDLE;
            end else begin
              res_q <= data_in;
              state <= STREAM;
            end
          end
        end
        STREAM: begin
          if (in_fire) begin
            valid_out <= 1'b1;
            res_q     <= data_in;
            if (s == '0) begin
              data_out <= data_in & bytes_of(keep_in);
              keep_out <= keep_in;
              last_out <= last_in;
              if (last_in) state <= IDLE;
            end else if (!last_in) begin
              data_out <= merged;
              keep_out <= '1;
              last_out <= 1'b0;
            end else if (n <= s_len) begin
              data_out <= merged & bytes_of(keep_of(tail_len));
              keep_out <= keep_of(tail_len);
              last_out <= 1'b1;
              state    <= IDLE;
            end else begin
              data_out    <= merged;
              keep_out    <= '1;
              last_out    <= 1'b0;
              flush_len_q <= flush_len;
              state       <= FLUSH;
            end
          end
        end
        FLUSH: begin
          if (out_free) begin
            valid_out <= 1'b1;
            data_out  <= tail_data & bytes_of(keep_of(flush_len_q));
            keep_out  <= keep_of(flush_len_q);
            last_out  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_stream_remove_header.sv
// Self-checking bench for axi_stream_remove_header: directed vector table, mid-packet
// reset, and random packets with random back-pressure checked by a byte-queue model.
module tb_axi_stream_remove_header;

  localparam int TMO = 1000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_len, ready_len;
  logic [2:0]  len_in;
  logic        valid_in, ready_in;
  logic [31:0] data_in;
  logic [3:0]  keep_in;
  logic        last_in;
  logic        valid_out, ready_out;
  logic [31:0] data_out;
  logic [3:0]  keep_out;
  logic        last_out;
  logic        valid_hdr, ready_hdr;
  logic [31:0] header_out;
  logic [3:0]  keep_hdr;

  axi_stream_remove_header #(.DATA_WD(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .valid_len(valid_len), .ready_len(ready_len), .len_in(len_in),
    .valid_in(valid_in), .ready_in(ready_in), .data_in(data_in),
    .keep_in(keep_in), .last_in(last_in),
    .valid_out(valid_out), .ready_out(ready_out), .data_out(data_out),
    .keep_out(keep_out), .last_out(last_out),
    .valid_hdr(valid_hdr), .ready_hdr(ready_hdr), .header_out(header_out),
    .keep_hdr(keep_hdr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
  } beat_t;

  typedef struct packed {
    logic [2:0]        len;
    logic [1:0]        nb_m1;
    logic [2:0][31:0]  d;
    logic [2:0][3:0]   k;
    logic [31:0]       hd;
    logic [3:0]        hk;
    logic [1:0]        np;
    logic [2:0][31:0]  pd;
    logic [2:0][3:0]   pk;
    logic [1:0]        post;   // 1: ready_len back after header, 2: ready_in low in flush
  } vec_t;

  vec_t  vecs [4];
  beat_t exp_pay[$];
  beat_t exp_hdr[$];
  int    n_cmp = 0;
  int    n_err = 0;
  bit    rand_rdy = 1'b0;

  task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    cmp({tag, "_valid_out"},  64'(valid_out),  64'd0);
    cmp({tag, "_data_out"},   64'(data_out),   64'd0);
    cmp({tag, "_keep_out"},   64'(keep_out),   64'd0);
    cmp({tag, "_last_out"},   64'(last_out),   64'd0);
    cmp({tag, "_valid_hdr"},  64'(valid_hdr),  64'd0);
    cmp({tag, "_header_out"}, 64'(header_out), 64'd0);
    cmp({tag, "_keep_hdr"},   64'(keep_hdr),   64'd0);
    cmp({tag, "_ready_in"},   64'(ready_in),   64'd0);
    cmp({tag, "_ready_len"},  64'(ready_len),  64'd0);
  endtask

  task automatic send_len(input logic [2:0] l);
    bit got = 1'b0;
    int t = 0;
    valid_len = 1'b1;
    len_in    = l;
    while (!got && t < TMO) begin
      @(negedge clk); got = ready_len; t++;
      @(posedge clk); #1;
    end
    valid_len = 1'b0;
    if (!got) begin
      n_cmp++; n_err++;
      $display("FAIL len_timeout: ready_len stayed 0 for %0d cycles, expected 1", TMO);
    end
  endtask

  task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l,
                           output int waited);
    bit got = 1'b0;
    waited   = 0;
    valid_in = 1'b1;
    data_in  = d;
    keep_in  = k;
    last_in  = l;
    while (!got && waited < TMO) begin
      @(negedge clk); got = ready_in; waited++;
      @(posedge clk); #1;
    end
    valid_in = 1'b0;
    if (!got) begin
      n_cmp++; n_err++;
      $display("FAIL beat_timeout: ready_in stayed 0 for %0d cycles, expected 1", TMO);
    end
  endtask

  task automatic apply_vec(input vec_t v);
    int w;
    exp_hdr.push_back(beat_t'{v.hd, v.hk, 1'b0});
    for (int j = 0; j < int'(v.np); j++)
      exp_pay.push_back(beat_t'{v.pd[j], v.pk[j], j == int'(v.np) - 1});
    send_len(v.len);
    for (int j = 0; j <= int'(v.nb_m1); j++) begin
      send_beat(v.d[j], v.k[j], j == int'(v.nb_m1), w);
      cmp("throughput", 64'(w), 64'd1);
    end
    if (v.post == 2'd1) cmp("ready_len_after_hdr", 64'(ready_len), 64'd1);
    if (v.post == 2'd2) cmp("ready_in_in_flush", 64'(ready_in), 64'd0);
  endtask

  task automatic rand_pkt();
    logic [7:0]  b[$];
    logic [31:0] d;
    logic [3:0]  k;
    int l, tot, hl, idx, nb, w;
    l   = $urandom_range(1, 4);
    tot = $urandom_range(1, 12);
    for (int i = 0; i < tot; i++) b.push_back(8'($urandom));
    hl = (l < tot) ? l : tot;
    d = '0; k = '0;
    for (int i = 0; i < hl; i++) begin d[31-8*i -: 8] = b[i]; k[3-i] = 1'b1; end
    exp_hdr.push_back(beat_t'{d, k, 1'b0});
    idx = hl;
    while (idx < tot) begin
      d = '0; k = '0;
      for (int j = 0; j < 4 && idx < tot; j++) begin
        d[31-8*j -: 8] = b[idx]; k[3-j] = 1'b1; idx++;
      end
      exp_pay.push_back(beat_t'{d, k, idx == tot});
    end
    send_len(3'(l));
    for (int bi = 0; bi * 4 < tot; bi++) begin
      nb = tot - 4 * bi;
      if (nb > 4) nb = 4;
      d = $urandom; k = '0;
      for (int j = 0; j < nb; j++) begin d[31-8*j -: 8] = b[4*bi+j]; k[3-j] = 1'b1; end
      send_beat(d, k, 4 * bi + nb == tot, w);
      if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
    end
  endtask

  task automatic drain();
    int t = 0;
    while ((exp_pay.size() != 0 || exp_hdr.size() != 0) && t < TMO) begin
      @(posedge clk); #1; t++;
    end
    if (exp_pay.size() != 0 || exp_hdr.size() != 0) begin
      n_cmp++; n_err++;
      $display("FAIL drain_timeout: %0d payload / %0d header beats outstanding, expected 0",
               exp_pay.size(), exp_hdr.size());
    end
  endtask

  // Back-pressure driver: all-ready in directed phases, random in the random phase.
  initial forever begin
    @(posedge clk); #1;
    if (rand_rdy) begin
      ready_out = 1'($urandom_range(0, 1));
      ready_hdr = 1'($urandom_range(0, 1));
    end else begin
      ready_out = 1'b1;
      ready_hdr = 1'b1;
    end
  end

  // Output monitor: scoreboard pops on handshake, hold check while stalled.
  initial begin
    bit    stall_o = 1'b0, stall_h = 1'b0;
    beat_t held_o, held_h, e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall_o = 1'b0; stall_h = 1'b0;
      end else begin
        if (stall_o) cmp("out_hold", 64'({valid_out, data_out, keep_out, last_out}),
                         64'({1'b1, held_o}));
        if (stall_h) cmp("hdr_hold", 64'({valid_hdr, header_out, keep_hdr}),
                         64'({1'b1, held_h.d, held_h.k}));
        if (valid_out && ready_out) begin
          if (exp_pay.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL payload_unexpected: got %h/%h/%b, expected no beat",
                     data_out, keep_out, last_out);
          end else begin
            e = exp_pay.pop_front();
            cmp("payload", 64'({data_out, keep_out, last_out}), 64'(e));
          end
        end
        if (valid_hdr && ready_hdr) begin
          if (exp_hdr.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL header_unexpected: got %h/%h, expected no header",
                     header_out, keep_hdr);
          end else begin
            e = exp_hdr.pop_front();
            cmp("header", 64'({header_out, keep_hdr}), 64'({e.d, e.k}));
          end
        end
        stall_o = valid_out && !ready_out;
        held_o  = beat_t'{data_out, keep_out, last_out};
        stall_h = valid_hdr && !ready_hdr;
        held_h  = beat_t'{header_out, keep_hdr, 1'b0};
      end
    end
  end

  initial begin
    int w;
    for (int i = 0; i < 4; i++) vecs[i] = '0;
    vecs[0].len = 3'd1; vecs[0].nb_m1 = 2'd2;
    vecs[0].d[0] = 32'hAABBCCDD; vecs[0].k[0] = 4'b1111;
    vecs[0].d[1] = 32'h11223344; vecs[0].k[1] = 4'b1111;
    vecs[0].d[2] = 32'h55667788; vecs[0].k[2] = 4'b1111;
    vecs[0].hd = 32'hAA000000; vecs[0].hk = 4'b1000; vecs[0].np = 2'd3;
    vecs[0].pd[0] = 32'hBBCCDD11; vecs[0].pk[0] = 4'b1111;
    vecs[0].pd[1] = 32'h22334455; vecs[0].pk[1] = 4'b1111;
    vecs[0].pd[2] = 32'h66778800; vecs[0].pk[2] = 4'b1110;

    vecs[1].len = 3'd4; vecs[1].nb_m1 = 2'd1;
    vecs[1].d[0] = 32'h01020304; vecs[1].k[0] = 4'b1111;
    vecs[1].d[1] = 32'hA1A2A3A4; vecs[1].k[1] = 4'b1100;
    vecs[1].hd = 32'h01020304; vecs[1].hk = 4'b1111; vecs[1].np = 2'd1;
    vecs[1].pd[0] = 32'hA1A20000; vecs[1].pk[0] = 4'b1100;

    vecs[2].len = 3'd3; vecs[2].nb_m1 = 2'd0;
    vecs[2].d[0] = 32'hAABBCCDD; vecs[2].k[0] = 4'b1100;
    vecs[2].hd = 32'hAABB0000; vecs[2].hk = 4'b1100; vecs[2].np = 2'd0;
    vecs[2].post = 2'd1;

    vecs[3].len = 3'd2; vecs[3].nb_m1 = 2'd1;
    vecs[3].d[0] = 32'h01020304; vecs[3].k[0] = 4'b1111;
    vecs[3].d[1] = 32'h05060708; vecs[3].k[1] = 4'b1110;
    vecs[3].hd = 32'h01020000; vecs[3].hk = 4'b1100; vecs[3].np = 2'd2;
    vecs[3].pd[0] = 32'h03040506; vecs[3].pk[0] = 4'b1111;
    vecs[3].pd[1] = 32'h07000000; vecs[3].pk[1] = 4'b1000;
    vecs[3].post = 2'd2;

    rst_n = 1'b0; valid_len = 1'b0; len_in = '0;
    valid_in = 1'b0; data_in = '0; keep_in = '0; last_in = 1'b0;
    ready_out = 1'b1; ready_hdr = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    rst_n = 1'b1;
    #1 cmp("ready_len_after_reset", 64'(ready_len), 64'd1);

    for (int i = 0; i < 4; i++) apply_vec(vecs[i]);
    drain();

    // Reset in the middle of STREAM, then a clean L=2 packet.
    exp_hdr.push_back(beat_t'{32'h01020000, 4'b1100, 1'b0});
    send_len(3'd2);
    send_beat(32'h01020304, 4'b1111, 1'b0, w);
    send_beat(32'h05060708, 4'b1111, 1'b0, w);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk_zero("mid_reset");
    rst_n = 1'b1;
    exp_pay.delete();
    exp_hdr.delete();
    #1 cmp("ready_len_after_mid_reset", 64'(ready_len), 64'd1);
    apply_vec(vecs[3]);
    drain();

    rand_rdy = 1'b1;
    for (int i = 0; i < 50; i++) rand_pkt();
    drain();
    rand_rdy = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    cmp("payload_queue_left", 64'(exp_pay.size()), 64'd0);
    cmp("header_queue_left", 64'(exp_hdr.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
